multicycle_control: RTL and testbench

Moore-style control FSM that sequences the shared-memory, single-ALU multi-cycle datapath over the fetch, decode, execute, memory and writeback steps. It sits beside the datapath and drives its mux selects, register enables and ALU operation. It decodes the instruction register's opcode/funct fields and the ALU zero flag. Execution runs from a `start` pulse until a HALT instruction or an illegal encoding.

---
 rtl/multicycle_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore-style control FSM for a shared-memory, single-ALU multi-cycle
// datapath. It steps each instruction through fetch, decode, execute,
// memory and writeback. It drives the datapath's mux selects, register
// enables and ALU operation.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 begins execution when the FSM is in IDLE
//   opcode, funct         instruction register fields IR[31:26], IR[5:0]
//   zero                  ALU zero flag (only affects pc_en in BEQ)
//   pc_en, pc_src         PC load enable and next-PC source select
//   iord                  memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write   memory strobes
//   ir_write              instruction register load
//   reg_dst, mem_to_reg   register file write address / data selects
//   reg_write             register file write enable
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_ctrl              ALU operation
//   busy, instr_done      status: executing / last cycle of an instruction
//   illegal               sticky undefined-encoding flag
//   state                 current state code for debug
//
// Configuration macro: MC_JUMP_EN builds the JUMP state and decodes opcode
// 000010 as j. Without it, that opcode is treated as illegal and pc_src
// never selects the jump target.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       busy,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_RTEXEC = 4'd7;
  localparam logic [3:0] S_RTWB   = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
`ifdef MC_JUMP_EN
  localparam logic [3:0] S_JUMP   = 4'd12;
`endif
  localparam logic [3:0] S_HALT   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] state_next;
  logic       set_illegal;
  logic [3:0] rt_ctrl;
  logic       funct_ok;

  // R-type funct decode; an unknown funct is reported through funct_ok.
  always_comb begin
    rt_ctrl  = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: rt_ctrl = ALU_ADD;
      6'b100010: rt_ctrl = ALU_SUB;
      6'b100100: rt_ctrl = ALU_AND;
      6'b100101: rt_ctrl = ALU_OR;
      6'b101010: rt_ctrl = ALU_SLT;
      default: begin
        rt_ctrl  = 4'b0000;
        funct_ok = 1'b0;
      end
    endcase
  end

  // Next-state logic. Every route into HALT on a bad encoding also raises
  // set_illegal, so the sticky flag is set on the same edge.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTEXEC;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_next = S_JUMP;
`endif
          OP_HALT:      state_next = S_HALT;
          default: begin
            state_next  = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = S_MEMWB;
      S_RTEXEC: begin
        if (funct_ok) begin
          state_next = S_RTWB;
        end else begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_ADDIWB: state_next = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   state_next = S_FETCH;
`endif
      S_HALT:   state_next = S_HALT;
      default: begin
        state_next  = S_HALT;
        set_illegal = 1'b1;
      end
    endcase
  end

  // State and sticky illegal flag; reset aborts immediately so every
  // state-decoded write enable drops in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Output decode from the state register. BEQ's pc_en follows zero.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 4'b0000;
    instr_done = 1'b0;
    busy       = (state != S_IDLE) && (state != S_HALT);
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        pc_en     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = rt_ctrl;
      end
      S_RTWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed testbench for multicycle_control. Each step compares the state
// code and a packed word of every output against hand-derived constants.
// Packed word order: {pc_en, pc_src, iord, mem_read, mem_write, ir_write,
// reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, busy,
// instr_done, illegal}.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic       busy;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // Hand-derived output words per state.
  localparam logic [19:0] W_ZERO    = 20'b0_00_0_0_0_0_0_0_0_0_00_0000_0_0_0;
  localparam logic [19:0] W_FETCH   = 20'b1_00_0_1_0_1_0_0_0_0_01_0010_1_0_0;
  localparam logic [19:0] W_DECODE  = 20'b0_00_0_0_0_0_0_0_0_0_11_0010_1_0_0;
  localparam logic [19:0] W_MEMADR  = 20'b0_00_0_0_0_0_0_0_0_1_10_0010_1_0_0;
  localparam logic [19:0] W_MEMRD   = 20'b0_00_1_1_0_0_0_0_0_0_00_0000_1_0_0;
  localparam logic [19:0] W_MEMWB   = 20'b0_00_0_0_0_0_0_1_1_0_00_0000_1_1_0;
  localparam logic [19:0] W_MEMWR   = 20'b0_00_1_0_1_0_0_0_0_0_00_0000_1_1_0;
  localparam logic [19:0] W_RT_ADD  = 20'b0_00_0_0_0_0_0_0_0_1_00_0010_1_0_0;
  localparam logic [19:0] W_RT_SUB  = 20'b0_00_0_0_0_0_0_0_0_1_00_0110_1_0_0;
  localparam logic [19:0] W_RT_SLT  = 20'b0_00_0_0_0_0_0_0_0_1_00_0111_1_0_0;
  localparam logic [19:0] W_RTWB    = 20'b0_00_0_0_0_0_1_0_1_0_00_0000_1_1_0;
  localparam logic [19:0] W_BEQ_T   = 20'b1_01_0_0_0_0_0_0_0_1_00_0110_1_1_0;
  localparam logic [19:0] W_BEQ_N   = 20'b0_01_0_0_0_0_0_0_0_1_00_0110_1_1_0;
  localparam logic [19:0] W_ADDIWB  = 20'b0_00_0_0_0_0_0_0_1_0_00_0000_1_1_0;
  localparam logic [19:0] W_HALT    = 20'b0_00_0_0_0_0_0_0_0_0_00_0000_0_0_0;
  localparam logic [19:0] W_HALT_IL = 20'b0_00_0_0_0_0_0_0_0_0_00_0000_0_0_1;
`ifdef MC_JUMP_EN
  localparam logic [19:0] W_JUMP    = 20'b1_10_0_0_0_0_0_0_0_0_00_0000_1_1_0;
`endif

  logic [19:0] out_word;
  assign out_word = {pc_en, pc_src, iord, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                     alu_ctrl, busy, instr_done, illegal};

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .busy       (busy),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive the instruction fields the FSM decodes.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  // Check the current state and outputs, then advance to just past the
  // next rising edge.
  task automatic expectCycle(input string tag, input logic [3:0] exp_state,
                             input logic [19:0] exp_word);
    checkOutput({tag, " state"}, {28'd0, state}, {28'd0, exp_state});
    checkOutput({tag, " outputs"}, {12'd0, out_word}, {12'd0, exp_word});
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset state", {28'd0, state}, 32'd0);
    checkOutput("reset outputs", {12'd0, out_word}, {12'd0, W_ZERO});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    doReset();
    expectCycle("idle hold", 4'd0, W_ZERO);

    $display("[TB] R-type add, lw, sw");
    pulseStart();
    expectCycle("add fetch", 4'd1, W_FETCH);
    expectCycle("add decode", 4'd2, W_DECODE);
    expectCycle("add exec", 4'd7, W_RT_ADD);
    expectCycle("add wb", 4'd8, W_RTWB);
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    expectCycle("lw fetch", 4'd1, W_FETCH);
    expectCycle("lw decode", 4'd2, W_DECODE);
    expectCycle("lw memadr", 4'd3, W_MEMADR);
    expectCycle("lw memrd", 4'd4, W_MEMRD);
    expectCycle("lw memwb", 4'd5, W_MEMWB);
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    expectCycle("sw fetch", 4'd1, W_FETCH);
    expectCycle("sw decode", 4'd2, W_DECODE);
    expectCycle("sw memadr", 4'd3, W_MEMADR);
    expectCycle("sw memwr", 4'd6, W_MEMWR);

    $display("[TB] beq taken / not taken");
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    expectCycle("beqT fetch", 4'd1, W_FETCH);
    expectCycle("beqT decode", 4'd2, W_DECODE);
    expectCycle("beqT exec", 4'd9, W_BEQ_T);
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    expectCycle("beqN fetch", 4'd1, W_FETCH);
    expectCycle("beqN decode", 4'd2, W_DECODE);
    expectCycle("beqN exec", 4'd9, W_BEQ_N);

    $display("[TB] R-type sub, slt, addi, halt");
    applyStimulus(6'b000000, 6'b100010, 1'b0);
    expectCycle("sub fetch", 4'd1, W_FETCH);
    expectCycle("sub decode", 4'd2, W_DECODE);
    expectCycle("sub exec", 4'd7, W_RT_SUB);
    expectCycle("sub wb", 4'd8, W_RTWB);
    applyStimulus(6'b000000, 6'b101010, 1'b0);
    expectCycle("slt fetch", 4'd1, W_FETCH);
    expectCycle("slt decode", 4'd2, W_DECODE);
    expectCycle("slt exec", 4'd7, W_RT_SLT);
    expectCycle("slt wb", 4'd8, W_RTWB);
    applyStimulus(6'b001000, 6'b000000, 1'b0);
    expectCycle("addi fetch", 4'd1, W_FETCH);
    expectCycle("addi decode", 4'd2, W_DECODE);
    expectCycle("addi exec", 4'd10, W_MEMADR);
    expectCycle("addi wb", 4'd11, W_ADDIWB);
    applyStimulus(6'b111111, 6'b000000, 1'b0);
    expectCycle("halt fetch", 4'd1, W_FETCH);
    expectCycle("halt decode", 4'd2, W_DECODE);
    expectCycle("halt enter", 4'd13, W_HALT);
    pulseStart();
    expectCycle("halt ignores start", 4'd13, W_HALT);
    expectCycle("halt hold", 4'd13, W_HALT);

    $display("[TB] illegal opcode");
    doReset();
    applyStimulus(6'b010101, 6'b000000, 1'b0);
    pulseStart();
    expectCycle("badop fetch", 4'd1, W_FETCH);
    expectCycle("badop decode", 4'd2, W_DECODE);
    expectCycle("badop halt", 4'd13, W_HALT_IL);
    expectCycle("badop sticky", 4'd13, W_HALT_IL);

    $display("[TB] illegal funct");
    doReset();
    applyStimulus(6'b000000, 6'b111000, 1'b0);
    pulseStart();
    expectCycle("badfn fetch", 4'd1, W_FETCH);
    expectCycle("badfn decode", 4'd2, W_DECODE);
    checkOutput("badfn exec state", {28'd0, state}, 32'd7);
    checkOutput("badfn exec reg_write", {31'd0, reg_write}, 32'd0);
    checkOutput("badfn exec illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #1;
    expectCycle("badfn halt", 4'd13, W_HALT_IL);

    $display("[TB] reset during MEMRD");
    doReset();
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    pulseStart();
    expectCycle("abort fetch", 4'd1, W_FETCH);
    expectCycle("abort decode", 4'd2, W_DECODE);
    expectCycle("abort memadr", 4'd3, W_MEMADR);
    checkOutput("abort memrd state", {28'd0, state}, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort async state", {28'd0, state}, 32'd0);
    checkOutput("abort async outputs", {12'd0, out_word}, {12'd0, W_ZERO});
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(6'b000000, 6'b100000, 1'b0);
    pulseStart();
    expectCycle("restart fetch", 4'd1, W_FETCH);

    $display("[TB] jump opcode");
    doReset();
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    pulseStart();
    expectCycle("j fetch", 4'd1, W_FETCH);
    expectCycle("j decode", 4'd2, W_DECODE);
`ifdef MC_JUMP_EN
    expectCycle("j exec", 4'd12, W_JUMP);
    expectCycle("j refetch", 4'd1, W_FETCH);
`else
    expectCycle("j illegal", 4'd13, W_HALT_IL);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
